// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the FIFO block.
// Default geometry and the pointer-width function used by fifo and fifo_mem.
package fifo_pkg;

  localparam int FIFO_DEFAULT_WIDTH = 8;
  localparam int FIFO_DEFAULT_DEPTH = 16;

  // Pointer width for a power-of-two depth; count needs one extra bit to reach DEPTH.
  function automatic int fifo_ptr_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: DEPTH x WIDTH register array with one synchronous write port
// and one synchronous read port whose output register holds until the next read.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_DEFAULT_WIDTH,
  parameter int DEPTH = FIFO_DEFAULT_DEPTH,
  parameter int AW    = fifo_ptr_width(FIFO_DEFAULT_DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q, rdata_d;

  // Storage is deliberately left out of reset; entries are only observable after being written.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem_q[raddr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/fifo.sv
// Synchronous FIFO: pointers, occupancy count, flags and read control around fifo_mem.
// Define FIFO_ASSERT_EN to compile in concurrent protocol assertions.
module fifo
  import fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_DEFAULT_WIDTH,
  parameter int DEPTH = FIFO_DEFAULT_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic             rd,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int PW = fifo_ptr_width(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          wr_acc, rd_acc;

  assign empty  = (count_q == '0);
  assign full   = (count_q == CNT_FULL);
  // Gating by the flags resolves wr+rd on empty (write only) and on full (read only).
  assign wr_acc = wr && !full;
  assign rd_acc = rd && !empty;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (wr_acc) begin
      wptr_d = wptr_q + PTR_ONE;
    end
    if (rd_acc) begin
      rptr_d = rptr_q + PTR_ONE;
    end
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst),
    .we    (wr_acc),
    .waddr (wptr_q),
    .wdata (din),
    .re    (rd_acc),
    .raddr (rptr_q),
    .rdata (dout)
  );

`ifdef FIFO_ASSERT_EN
  a_not_empty_and_full: assert property (@(posedge clk) disable iff (!rst)
    !(empty && full));

  a_full_means_depth: assert property (@(posedge clk) disable iff (!rst)
    full |-> (count_q == CNT_FULL));

  a_wr_full_holds_wptr: assert property (@(posedge clk) disable iff (!rst)
    (wr && full) |=> (wptr_q == $past(wptr_q)));

  a_rd_empty_holds_rptr: assert property (@(posedge clk) disable iff (!rst)
    (rd && empty) |=> (rptr_q == $past(rptr_q)));

  a_wr_empty_clears_empty: assert property (@(posedge clk) disable iff (!rst)
    (wr && empty) |=> !empty);
`endif

endmodule

// File: tb/tb_fifo.sv
// Directed testbench for fifo: queue-based reference model checked every cycle,
// plus hand-computed literal expectations for each scenario.
module tb_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             wr  = 1'b0;
  logic             rd  = 1'b0;
  logic [WIDTH-1:0] din = '0;
  logic [WIDTH-1:0] dout;
  logic             empty;
  logic             full;

  int total = 0;
  int bad   = 0;

  logic [WIDTH-1:0] m_q [$];
  logic [WIDTH-1:0] m_dout = '0;

  fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .wr    (wr),
    .rd    (rd),
    .din   (din),
    .dout  (dout),
    .empty (empty),
    .full  (full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a queue of stored words and the last word read out.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_q.delete();
      m_dout <= '0;
    end else begin
      if (rd && m_q.size() != 0) begin
        m_dout <= m_q.pop_front();
      end
      if (wr && (m_q.size() < DEPTH || (rd && m_q.size() != 0))) begin
        m_q.push_back(din);
      end
    end
  end

  always @(negedge clk) begin
    chk("cyc_dout",  int'(dout),        int'(m_dout));
    chk("cyc_empty", int'(empty),       int'(m_q.size() == 0));
    chk("cyc_full",  int'(full),        int'(m_q.size() == DEPTH));
    chk("cyc_count", int'(dut.count_q), m_q.size());
  end

  task automatic step(input logic w, input logic r, input logic [WIDTH-1:0] d);
    wr  = w;
    rd  = r;
    din = d;
    @(negedge clk);
    $display("cycle t=%0t wr=%0b rd=%0b din=%02h -> dout=%02h empty=%0b full=%0b",
             $time, w, r, d, dout, empty, full);
  endtask

  initial begin
    logic [1:0] combo;
    @(negedge clk);

    // Reset held low while every wr/rd combination is presented.
    for (int i = 0; i < 4; i++) begin
      combo = 2'(i);
      step(combo[1], combo[0], 8'h5A);
      chk("rst_empty", int'(empty), 1);
      chk("rst_full",  int'(full),  0);
      chk("rst_dout",  int'(dout),  0);
    end
    wr = 1'b0; rd = 1'b0;
    rst = 1'b1;
    @(negedge clk);

    // Reads on an empty FIFO are ignored.
    step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b1, 8'h00);
    chk("rdempty_empty", int'(empty),       1);
    chk("rdempty_dout",  int'(dout),        0);
    chk("rdempty_rptr",  int'(dut.rptr_q),  0);

    // Fill: 15 writes, then the 16th sets full, the 17th (0xAA) is dropped.
    for (int i = 0; i < 15; i++) step(1'b1, 1'b0, 8'(8'h10 + i));
    chk("fill15_empty", int'(empty), 0);
    chk("fill15_full",  int'(full),  0);
    step(1'b1, 1'b0, 8'h1F);
    chk("fill16_full", int'(full), 1);
    step(1'b1, 1'b0, 8'hAA);
    chk("fill17_full",  int'(full),        1);
    chk("fill17_count", int'(dut.count_q), 16);

    // Drain in write order; a 17th read leaves dout alone.
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 8'h00);
      chk("drain_dout", int'(dout), 8'h10 + i);
    end
    chk("drain_empty", int'(empty), 1);
    step(1'b0, 1'b1, 8'h00);
    chk("drain17_dout", int'(dout), 8'h1F);

    // Wrap: write 10, read 8, then 20 simultaneous cycles holding count at 2.
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 8'(8'h40 + i));
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'h00);
    chk("wrap_pre_dout", int'(dout), 8'h47);
    for (int k = 0; k < 20; k++) begin
      step(1'b1, 1'b1, 8'(8'h80 + k));
      chk("sim_dout",  int'(dout), (k < 2) ? (8'h48 + k) : (8'h80 + k - 2));
      chk("sim_count", int'(dut.count_q), 2);
      chk("sim_empty", int'(empty), 0);
      chk("sim_full",  int'(full),  0);
    end

    // Mid-operation asynchronous reset between clock edges.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'hC0 + i));
    wr = 1'b0; rd = 1'b0;
    #1 rst = 1'b0;
    #1;
    chk("midrst_empty", int'(empty), 1);
    chk("midrst_dout",  int'(dout),  0);
    #1 rst = 1'b1;
    @(negedge clk);
    step(1'b0, 1'b1, 8'h00);
    chk("postrst_dout",  int'(dout),  0);
    chk("postrst_empty", int'(empty), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
